wave_voice_sched: RTL and testbench

Time-multiplexed voice scheduler that shares one combinational 64-entry wave table (6-bit ramp in, signed 16-bit sample out) among `VOICES` voices. On each sample strobe it steps every voice's phase accumulator, reads that voice's table sample, scales it by the voice volume and sums the results into one saturated 16-bit mix sample. It sits between the CPU-side sound register file and the audio DAC/PWM stage in the audio subsystem.

---
 rtl/audio_pkg.sv | 31 +++
 rtl/wave_voice_sched_if.sv | 35 +++
 rtl/wave_voice_regs.sv | 100 ++++++++++
 rtl/wave_voice_sched.sv | 159 +++++++++++++++
 tb/tb_wave_voice_sched.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_pkg
// Description : Shared types, constants and helpers for the voice scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

  localparam int RAMP_W   = 6;
  localparam int SAMPLE_W = 16;

  // Configuration field select (low bit of cfg_addr)
  localparam logic CFG_FIELD_INC = 1'b0;
  localparam logic CFG_FIELD_GV  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_ACC  = 2'd2,
    ST_OUT  = 2'd3
  } sched_state_t;

  // Clamp a wide signed sum into the signed 16-bit sample range
  function automatic logic [SAMPLE_W-1:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)       return 16'h7FFF;
    else if (v < -32'sd32768) return 16'h8000;
    else                      return v[SAMPLE_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/wave_voice_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : wave_voice_sched_if
// Description : Config, wave-table and mix-output bundle of the scheduler.
//               master = CPU/table/DAC side, slave = scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface wave_voice_sched_if #(
  parameter int VOICES = 4
);
  localparam int AW = $clog2(VOICES) + 1;

  logic          sample_en;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [15:0]   cfg_wdata;
  logic [5:0]    ramp_o;
  logic [15:0]   wave_data;
  logic [15:0]   mix_o;
  logic          mix_valid;
  logic          busy_o;
  logic          overrun_o;
  logic          ovr_clr;

  modport master (
    output sample_en, cfg_we, cfg_addr, cfg_wdata, wave_data, ovr_clr,
    input  ramp_o, mix_o, mix_valid, busy_o, overrun_o
  );

  modport slave (
    input  sample_en, cfg_we, cfg_addr, cfg_wdata, wave_data, ovr_clr,
    output ramp_o, mix_o, mix_valid, busy_o, overrun_o
  );
endinterface
`default_nettype wire

// File: rtl/wave_voice_regs.sv
`default_nettype none
// ============================================================================
// Module      : wave_voice_regs
// Description : Per-voice shadow/active register file with key-on detect.
//               Shadows take writes at any time; the active set is loaded
//               only on frame acceptance so a frame never sees a torn config.
//               WAVE_SCHED_VOLUME_EN : also keep per-voice 4-bit volume.
// Revision    : 1.0 - initial release
// ============================================================================
module wave_voice_regs
  import audio_pkg::*;
#(
  parameter int VOICES = 4,
  parameter int AW     = $clog2(VOICES) + 1
) (
  input  wire                      clk,
  input  wire                      reset_n,
  input  wire                      i_cfg_we,
  input  wire  [AW-1:0]            i_cfg_addr,
  input  wire  [15:0]              i_cfg_wdata,
  input  wire                      i_accept,
  output logic [VOICES-1:0][15:0]  o_inc,
  output logic [VOICES-1:0]        o_gate,
`ifdef WAVE_SCHED_VOLUME_EN
  output logic [VOICES-1:0][3:0]   o_vol,
`endif
  output logic [VOICES-1:0]        o_keyon
);
  localparam int IDX_W = $clog2(VOICES);

  logic [VOICES-1:0][15:0] r_inc_s, r_inc, w_inc_nx;
  logic [VOICES-1:0]       r_gate_s, r_gate, w_gate_nx;
`ifdef WAVE_SCHED_VOLUME_EN
  logic [VOICES-1:0][3:0]  r_vol_s, r_vol, w_vol_nx;
`endif
  logic [IDX_W-1:0]        w_voice;
  logic                    w_field;

  assign w_voice = i_cfg_addr[AW-1:1];
  assign w_field = i_cfg_addr[0];

  // Shadow contents including a write landing this cycle; the active set
  // loads from here so a write coinciding with acceptance takes effect now
  always_comb begin
    for (int v = 0; v < VOICES; v++) begin
      w_inc_nx[v]  = r_inc_s[v];
      w_gate_nx[v] = r_gate_s[v];
`ifdef WAVE_SCHED_VOLUME_EN
      w_vol_nx[v]  = r_vol_s[v];
`endif
      if (i_cfg_we && (w_voice == v[IDX_W-1:0])) begin
        if (w_field == CFG_FIELD_INC) begin
          w_inc_nx[v] = i_cfg_wdata;
        end else if (w_field == CFG_FIELD_GV) begin
          w_gate_nx[v] = i_cfg_wdata[4];
`ifdef WAVE_SCHED_VOLUME_EN
          w_vol_nx[v]  = i_cfg_wdata[3:0];
`endif
        end
      end
    end
  end

  // Shadow update every cycle, active copy on frame acceptance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inc_s  <= '0;
      r_gate_s <= '0;
      r_inc    <= '0;
      r_gate   <= '0;
`ifdef WAVE_SCHED_VOLUME_EN
      r_vol_s  <= '0;
      r_vol    <= '0;
`endif
    end else begin
      r_inc_s  <= w_inc_nx;
      r_gate_s <= w_gate_nx;
`ifdef WAVE_SCHED_VOLUME_EN
      r_vol_s  <= w_vol_nx;
`endif
      if (i_accept) begin
        r_inc  <= w_inc_nx;
        r_gate <= w_gate_nx;
`ifdef WAVE_SCHED_VOLUME_EN
        r_vol  <= w_vol_nx;
`endif
      end
    end
  end

  // Rising gate at acceptance restarts that voice's phase
  assign o_keyon = {VOICES{i_accept}} & w_gate_nx & ~r_gate;
  assign o_inc   = r_inc;
  assign o_gate  = r_gate;
`ifdef WAVE_SCHED_VOLUME_EN
  assign o_vol   = r_vol;
`endif

endmodule
`default_nettype wire

// File: rtl/wave_voice_sched.sv
`default_nettype none
// ============================================================================
// Module      : wave_voice_sched
// Description : Time-multiplexed voice scheduler sharing one external wave
//               table; steps phases, scales and sums voices into one
//               saturated 16-bit mix sample per sample strobe.
//               WAVE_SCHED_VOLUME_EN : enable 4-bit per-voice volume scaling;
//               undefined, a gated voice contributes its full sample.
// Revision    : 1.0 - initial release
// ============================================================================
module wave_voice_sched
  import audio_pkg::*;
#(
  parameter int VOICES  = 4,
  parameter int PHASE_W = 24
) (
  input wire                clk,
  input wire                reset_n,
  wave_voice_sched_if.slave bus
);
  localparam int IDX_W = $clog2(VOICES);
  localparam int AW    = IDX_W + 1;
  localparam int ACC_W = SAMPLE_W + IDX_W + 1;
  localparam logic [IDX_W-1:0] c_LAST = IDX_W'(VOICES - 1);

  sched_state_t                r_state;
  logic [IDX_W-1:0]            r_idx;
  logic [SAMPLE_W-1:0]         r_sample;
  logic signed [ACC_W-1:0]     r_acc;
  logic [PHASE_W-1:0]          r_phase [VOICES];
  logic [RAMP_W-1:0]           r_ramp;
  logic [SAMPLE_W-1:0]         r_mix;
  logic                        r_mix_valid;
  logic                        r_busy;
  logic                        r_ovr;

  logic [VOICES-1:0][15:0]     w_inc;
  logic [VOICES-1:0]           w_gate;
  logic [VOICES-1:0]           w_keyon;
  logic                        w_accept;
  logic [IDX_W-1:0]            w_idx_nx;
  logic signed [ACC_W-1:0]     w_term;
  logic signed [ACC_W-1:0]     w_term_g;
  logic signed [ACC_W-1:0]     w_sum;

  assign w_accept = bus.sample_en && (r_state == ST_IDLE);
  assign w_idx_nx = r_idx + 1'b1;

`ifdef WAVE_SCHED_VOLUME_EN
  logic [VOICES-1:0][3:0]      w_vol;
  logic signed [20:0]          w_prod;
  logic signed [20:0]          w_scaled;

  wave_voice_regs #(.VOICES(VOICES), .AW(AW)) u_regs (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_cfg_we    (bus.cfg_we),
    .i_cfg_addr  (bus.cfg_addr),
    .i_cfg_wdata (bus.cfg_wdata),
    .i_accept    (w_accept),
    .o_inc       (w_inc),
    .o_gate      (w_gate),
    .o_vol       (w_vol),
    .o_keyon     (w_keyon)
  );

  // Sample times 0..15 volume, then /16 with floor (arithmetic shift)
  assign w_prod   = $signed({{5{r_sample[SAMPLE_W-1]}}, r_sample})
                  * $signed({17'd0, w_vol[r_idx]});
  assign w_scaled = w_prod >>> 4;
  assign w_term   = $signed(w_scaled[ACC_W-1:0]);
`else
  wave_voice_regs #(.VOICES(VOICES), .AW(AW)) u_regs (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_cfg_we    (bus.cfg_we),
    .i_cfg_addr  (bus.cfg_addr),
    .i_cfg_wdata (bus.cfg_wdata),
    .i_accept    (w_accept),
    .o_inc       (w_inc),
    .o_gate      (w_gate),
    .o_keyon     (w_keyon)
  );

  assign w_term = $signed({{(ACC_W-SAMPLE_W){r_sample[SAMPLE_W-1]}}, r_sample});
`endif

  assign w_term_g = w_gate[r_idx] ? w_term : '0;
  assign w_sum    = r_acc + w_term_g;

  // Scheduler: IDLE -> (RD,ACC) per voice -> OUT, with phase stepping,
  // accumulation and registered mix/ramp/status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_sample    <= '0;
      r_acc       <= '0;
      r_ramp      <= '0;
      r_mix       <= '0;
      r_mix_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_ovr       <= 1'b0;
      for (int v = 0; v < VOICES; v++) r_phase[v] <= '0;
    end else begin
      r_mix_valid <= 1'b0;
      // A strobe while busy is dropped; the sticky flag records it and wins
      // over a simultaneous clear
      if (bus.sample_en && (r_state != ST_IDLE)) r_ovr <= 1'b1;
      else if (bus.ovr_clr)                      r_ovr <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            for (int v = 0; v < VOICES; v++)
              if (w_keyon[v]) r_phase[v] <= '0;
            r_ramp  <= w_keyon[0] ? '0 : r_phase[0][PHASE_W-1 -: RAMP_W];
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RD;
          end
        end
        ST_RD: begin
          r_sample <= bus.wave_data;
          r_state  <= ST_ACC;
        end
        ST_ACC: begin
          if (w_gate[r_idx])
            r_phase[r_idx] <= r_phase[r_idx] + PHASE_W'(w_inc[r_idx]);
          if (r_idx == c_LAST) begin
            // Mix is registered here so it is visible during OUT
            r_mix       <= sat16($signed({{(32-ACC_W){w_sum[ACC_W-1]}}, w_sum}));
            r_mix_valid <= 1'b1;
            r_acc       <= '0;
            r_state     <= ST_OUT;
          end else begin
            r_acc   <= w_sum;
            r_idx   <= w_idx_nx;
            r_ramp  <= r_phase[w_idx_nx][PHASE_W-1 -: RAMP_W];
            r_state <= ST_RD;
          end
        end
        ST_OUT: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ramp_o    = r_ramp;
  assign bus.mix_o     = r_mix;
  assign bus.mix_valid = r_mix_valid;
  assign bus.busy_o    = r_busy;
  assign bus.overrun_o = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_wave_voice_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_wave_voice_sched
// Description : Self-checking bench for wave_voice_sched. A frame-level model
//               pushes expected ramp indices and mix samples at each accepted
//               strobe; a monitor pops and compares them as the DUT emits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wave_voice_sched;

  localparam int V  = 4;
  localparam int PW = 24;
`ifdef WAVE_SCHED_VOLUME_EN
  localparam bit VOL_EN = 1'b1;
`else
  localparam bit VOL_EN = 1'b0;
`endif

  typedef struct {
    int          cyc;
    logic [15:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  exp_t mix_q[$];
  exp_t ramp_q[$];
  exp_t e_mon;

  bit          tbl_mode;
  logic [15:0] tbl_const;

  // Frame-level reference state
  logic [15:0] m_inc_s [V];
  logic        m_gate_s[V];
  logic [3:0]  m_vol_s [V];
  logic [15:0] m_inc   [V];
  logic        m_gate  [V];
  logic [3:0]  m_vol   [V];
  int unsigned m_phase [V];
  int          m_T;

  wave_voice_sched_if #(.VOICES(V)) bus ();

  wave_voice_sched #(.VOICES(V), .PHASE_W(PW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External wave table: constant, or a ramp-dependent pattern
  assign bus.wave_data = tbl_mode ? {bus.ramp_o, 10'h2A5} : tbl_const;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int tbl_val(input logic [5:0] r);
    logic signed [15:0] s;
    s = tbl_mode ? {r, 10'h2A5} : tbl_const;
    return int'(s);
  endfunction

  function automatic logic [15:0] ref_sat(input int v);
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  task automatic model_reset();
    for (int v = 0; v < V; v++) begin
      m_inc_s[v] = '0; m_gate_s[v] = 1'b0; m_vol_s[v] = '0;
      m_inc[v]   = '0; m_gate[v]   = 1'b0; m_vol[v]   = '0;
      m_phase[v] = 0;
    end
  endtask

  task automatic model_write(input int voice, input int field, input logic [15:0] d);
    if (field == 0) m_inc_s[voice] = d;
    else begin
      m_gate_s[voice] = d[4];
      m_vol_s[voice]  = d[3:0];
    end
  endtask

  // Compute the whole frame at acceptance time (current cycle = T)
  task automatic model_accept();
    int          acc;
    int          s;
    int          t;
    logic [5:0]  r;
    m_T = cyc;
    acc = 0;
    for (int v = 0; v < V; v++) begin
      if (m_gate_s[v] && !m_gate[v]) m_phase[v] = 0;
      m_inc[v]  = m_inc_s[v];
      m_gate[v] = m_gate_s[v];
      m_vol[v]  = m_vol_s[v];
    end
    for (int v = 0; v < V; v++) begin
      r = 6'(m_phase[v] >> (PW - 6));
      ramp_q.push_back('{m_T + 1 + 2 * v, {10'd0, r}});
      s = tbl_val(r);
      if (m_gate[v]) begin
        t = VOL_EN ? ((s * int'(m_vol[v])) >>> 4) : s;
        acc += t;
        m_phase[v] = (m_phase[v] + int'(m_inc[v])) & 32'h00FF_FFFF;
      end
    end
    mix_q.push_back('{m_T + 1 + 2 * V, ref_sat(acc)});
  endtask

  task automatic cfg_write(input int voice, input int field, input logic [15:0] d);
    @(posedge clk); #1;
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 3'(voice * 2 + field);
    bus.cfg_wdata = d;
    model_write(voice, field, d);
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
  endtask

  // Accepted strobe, optionally with a config write in the same cycle
  task automatic strobe(input bit wr, input int voice, input int field, input logic [15:0] d);
    @(posedge clk); #1;
    bus.sample_en = 1'b1;
    if (wr) begin
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = 3'(voice * 2 + field);
      bus.cfg_wdata = d;
      model_write(voice, field, d);
    end
    model_accept();
    @(posedge clk); #1;
    bus.sample_en = 1'b0;
    bus.cfg_we    = 1'b0;
    check("busy_hi", {31'd0, bus.busy_o}, 32'd1);
  endtask

  // Return once the frame reaches OUT; the next strobe lands at OUT+1
  task automatic finish_frame();
    while (cyc < m_T + 2 * V + 1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ramp"},  {26'd0, bus.ramp_o},    32'd0);
    check({tag, "_mix"},   {16'd0, bus.mix_o},     32'd0);
    check({tag, "_valid"}, {31'd0, bus.mix_valid}, 32'd0);
    check({tag, "_busy"},  {31'd0, bus.busy_o},    32'd0);
    check({tag, "_ovr"},   {31'd0, bus.overrun_o}, 32'd0);
  endtask

  // Scoreboard monitor, sampling on the falling edge
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.mix_valid) begin
        if (mix_q.size() == 0) check("mix_unexpected", 32'd1, 32'd0);
        else begin
          e_mon = mix_q.pop_front();
          check("mix_val", {16'd0, bus.mix_o}, {16'd0, e_mon.val});
          check("mix_cyc", cyc, e_mon.cyc);
        end
      end else if (mix_q.size() > 0 && cyc > mix_q[0].cyc) begin
        e_mon = mix_q.pop_front();
        check("mix_missing", 32'd0, 32'd1);
      end
      if (ramp_q.size() > 0 && ramp_q[0].cyc == cyc) begin
        e_mon = ramp_q.pop_front();
        check("ramp", {26'd0, bus.ramp_o}, {16'd0, e_mon.val});
      end else if (ramp_q.size() > 0 && ramp_q[0].cyc < cyc) begin
        e_mon = ramp_q.pop_front();
        check("ramp_missing", 32'd0, 32'd1);
      end
    end
  end

  initial begin
    reset_n       = 1'b0;
    bus.sample_en = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    bus.ovr_clr   = 1'b0;
    tbl_mode      = 1'b0;
    tbl_const     = 16'h2000;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset_n = 1'b1;

    // Single voice, constant table
    cfg_write(0, 0, 16'h0400);
    cfg_write(0, 1, 16'h001F);
    strobe(1'b0, 0, 0, 16'h0);
    finish_frame();
    check("t1_mix", {16'd0, bus.mix_o}, VOL_EN ? 32'h1E00 : 32'h2000);
    check("t1_phase0", {8'd0, dut.r_phase[0]}, 32'h0000_0400);

    // Saturation in both directions
    for (int v = 1; v < V; v++) cfg_write(v, 1, 16'h001F);
    tbl_const = 16'h7FFF;
    strobe(1'b0, 0, 0, 16'h0);
    finish_frame();
    check("sat_pos", {16'd0, bus.mix_o}, 32'h7FFF);
    tbl_const = 16'h8000;
    strobe(1'b0, 0, 0, 16'h0);
    finish_frame();
    check("sat_neg", {16'd0, bus.mix_o}, 32'h8000);

    // Phase wrap: 512 frames of 0x8000 sweep ramp 0..63 and return to 0
    tbl_const = 16'h0100;
    cfg_write(1, 0, 16'h8000);
    for (int f = 0; f < 512; f++) begin
      strobe(1'b0, 0, 0, 16'h0);
      finish_frame();
    end
    check("wrap_phase1", {8'd0, dut.r_phase[1]}, 32'd0);
    for (int f = 0; f < 20; f++) begin
      strobe(1'b0, 0, 0, 16'h0);
      finish_frame();
    end

    // Key-on: gate off then on restarts voice 1 at ramp 0
    cfg_write(1, 1, 16'h000F);
    strobe(1'b0, 0, 0, 16'h0);
    finish_frame();
    cfg_write(1, 1, 16'h001F);
    strobe(1'b0, 0, 0, 16'h0);
    finish_frame();
    check("keyon_phase1", {8'd0, dut.r_phase[1]}, 32'h0000_8000);

    // Mid-frame increment write must not alter the current frame
    strobe(1'b0, 0, 0, 16'h0);
    cfg_write(2, 0, 16'h4321);
    finish_frame();
    strobe(1'b0, 0, 0, 16'h0);
    finish_frame();

    // Config write on the acceptance cycle takes effect in that frame
    strobe(1'b1, 3, 1, 16'h0000);
    finish_frame();

    // Overrun: strobe at T+3 is ignored and sets the sticky flag
    strobe(1'b0, 0, 0, 16'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.sample_en = 1'b1;
    @(posedge clk); #1;
    bus.sample_en = 1'b0;
    check("ovr_set", {31'd0, bus.overrun_o}, 32'd1);
    finish_frame();
    @(posedge clk); #1;
    bus.ovr_clr = 1'b1;
    @(posedge clk); #1;
    bus.ovr_clr = 1'b0;
    check("ovr_clr", {31'd0, bus.overrun_o}, 32'd0);
    strobe(1'b0, 0, 0, 16'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.sample_en = 1'b1;
    bus.ovr_clr   = 1'b1;
    @(posedge clk); #1;
    bus.sample_en = 1'b0;
    bus.ovr_clr   = 1'b0;
    check("ovr_set_wins", {31'd0, bus.overrun_o}, 32'd1);
    finish_frame();
    @(posedge clk); #1;
    bus.ovr_clr = 1'b1;
    @(posedge clk); #1;
    bus.ovr_clr = 1'b0;

    // Randomised frames against a ramp-dependent table
    tbl_mode = 1'b1;
    for (int f = 0; f < 24; f++) begin
      cfg_write($urandom_range(V - 1), $urandom_range(1), 16'($urandom));
      strobe(1'b0, 0, 0, 16'h0);
      if ($urandom_range(1) == 1) cfg_write($urandom_range(V - 1), $urandom_range(1), 16'($urandom));
      finish_frame();
    end

    // Reset mid-frame: frame aborted, outputs cleared
    tbl_mode = 1'b0;
    strobe(1'b0, 0, 0, 16'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    mix_q.delete();
    ramp_q.delete();
    model_reset();
    #1;
    check_reset_outputs("abort");
    repeat (12) @(posedge clk);
    #1;
    check("abort_novalid", {31'd0, bus.mix_valid}, 32'd0);
    reset_n = 1'b1;

    // First frame after reset: gate on, volume 0, table 0x1000
    tbl_const = 16'h1000;
    cfg_write(0, 1, 16'h0010);
    strobe(1'b0, 0, 0, 16'h0);
    finish_frame();
    check("vol0_mix", {16'd0, bus.mix_o}, VOL_EN ? 32'h0000 : 32'h1000);

    for (int i = 0; i < 40 && (mix_q.size() > 0 || ramp_q.size() > 0); i++) @(posedge clk);
    check("drain", mix_q.size() + ramp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
